dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port round-robin arbiter that shares the single-cycle data memory (dmem) between two requesters:
- m0: the core load/store port.
- m1: a DMA/debug port.

It performs at most one word access per cycle on dmem's combinational-read / posedge-write interface. It registers read data back to the granted requester one cycle later and flags out-of-range accesses. It sits between the core datapath/DMA engine and dmem.

Parameters:
- MEM_DEPTH, 256: number of 32-bit words in the attached dmem; used for the range check.
- MAX_LOCK, 4: maximum consecutive locked m1 grants (used only with DMEM_ARB_LOCK_EN).

Ports:
- clk input 1: system clock; all state updates on rising edge.
- rst_n input 1: asynchronous active-low reset.
- m0_req input 1: m0 access request, held until granted.
- m0_we input 1: m0 write (1) / read (0).
- m0_addr input 32: m0 byte address; bits [1:0] ignored.
- m0_wdata input 32: m0 write data.
- m0_gnt output 1: m0 access accepted this cycle (combinational).
- m0_rvalid output 1: registered response for the m0 access accepted last cycle.
- m0_rdata output 32: registered read data; 0 for writes or errors.
- m0_err output 1: registered; the last accepted m0 access was out of range.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as m0 for port m1.
- mem_read output 1: to dmem MemRead.
- mem_write output 1: to dmem MemWrite.
- mem_addr output 32: to dmem addr.
- mem_wdata output 32: to dmem write_data.
- mem_rdata input 32: from dmem read_data.

Behaviour:
- Reset (async, rst_n=0): all rvalid/err=0, rdata=0, prio pointer=0 (m0 preferred), lock counter=0. Grant outputs are 0 while rst_n=0. Reset mid-access abandons the pending response; there is no rvalid after reset.
- State: a 1-bit prio pointer selects the preferred port on conflict, plus the response registers.
- Arbitration, combinational each cycle:
  - Only m0_req: grant m0.
  - Only m1_req: grant m1.
  - Both: grant the port named by prio.
  - Neither: no grant; mem_read=mem_write=0.
- Pointer update: on any grant, prio <= the non-granted port. Idle cycles leave prio unchanged.
- Memory drive:
  - mem_addr and mem_wdata are muxed from the granted port, or 0 when idle.
  - mem_write = gnt & we & in_range.
  - mem_read = gnt & ~we & in_range.
  - The write commits at the same rising edge that ends the grant cycle.
- Range check: in_range = (addr[31:2] < MEM_DEPTH). An out-of-range access is still granted but suppressed: no mem_read/mem_write.
- Response, 1-cycle latency: at the edge ending a grant cycle to port p:
  - p_rvalid <= 1.
  - p_rdata <= (read & in_range) ? mem_rdata : 0.
  - p_err <= ~in_range.
  - The other port's rvalid <= 0.
  - With no grant, both rvalid <= 0. rdata and err hold their last value.
- Throughput: one access per cycle. Back-to-back grants to the same port are allowed when the other port is idle.
- A requester that is not granted must hold req/we/addr/wdata stable. The arbiter does not latch them.
- No starvation: a continuously requesting port waits at most 1 cycle (2 with lock disabled-equivalent timing).

Optional Feature:
Macro: DMEM_ARB_LOCK_EN.
- Defined:
  - Adds input m1_lock (1 bit).
  - While m1 is granted with m1_lock=1, prio is forced to m1 and a lock counter increments.
  - When the counter reaches MAX_LOCK, prio goes to m0 for one arbitration and the counter clears.
  - The counter also clears on any m0 grant or when m1_lock=0.
  - Worst-case m0 wait is MAX_LOCK cycles.
- Undefined: the m1_lock port is absent; the block is pure round-robin as above.

Test Plan:
1. Reset then m0 write addr 0x10, data 0xDEADBEEF; then m0 read 0x10 -> m0_gnt=1 each cycle; mem_write=1 then mem_read=1; m0_rvalid=1 with m0_rdata=0xDEADBEEF one cycle after the read grant.
2. Both req continuously (m0 read 0x0, m1 read 0x4) from reset -> grants alternate m0,m1,m0,m1; each port's rvalid follows its grant by 1 cycle.
3. m1 write 0x400 (word 256, MEM_DEPTH=256) -> m1_gnt=1, mem_write=0, next cycle m1_err=1 with m1_rdata=0; dmem contents unchanged.
4. rst_n pulled low during an m0 read grant cycle -> m0_rvalid/m0_rdata/m0_err go to 0 immediately and stay 0 after release; prio=m0.
5. Only m1 requesting for 3 cycles, then both -> m1 granted 3 times; on the conflict cycle m0 is granted (prio points to m0).
6. With DMEM_ARB_LOCK_EN, MAX_LOCK=4: both requesting, m1_lock=1 -> m1 gets 4 consecutive grants after its first win, then m0 gets 1, then m1 resumes.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-cycle dmem between m0 and m1.
// Optional m1 bus lock with bounded hold when DMEM_ARB_LOCK_EN is defined.
module dmem_arbiter #(
  parameter int MEM_DEPTH = 256,
  parameter int MAX_LOCK  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic        m1_lock,
`endif
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  logic        prio_q, prio_d;
  logic        any_gnt;
  logic        sel_we;
  logic        sel_inr;
  logic [31:0] sel_rd;

  function automatic logic in_rng(input logic [31:0] a);
    return {2'b00, a[31:2]} < $unsigned(MEM_DEPTH);
  endfunction

  // prio_q = 0 prefers m0, 1 prefers m1
  assign m0_gnt  = rst_n & m0_req & (~m1_req | ~prio_q);
  assign m1_gnt  = rst_n & m1_req & (~m0_req | prio_q);
  assign any_gnt = m0_gnt | m1_gnt;

  always_comb begin
    sel_we    = 1'b0;
    sel_inr   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      m0_gnt: begin
        sel_we    = m0_we;
        sel_inr   = in_rng(m0_addr);
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
      end
      m1_gnt: begin
        sel_we    = m1_we;
        sel_inr   = in_rng(m1_addr);
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  assign mem_write = any_gnt & sel_we & sel_inr;
  assign mem_read  = any_gnt & ~sel_we & sel_inr;
  assign sel_rd    = mem_read ? mem_rdata : '0;

`ifdef DMEM_ARB_LOCK_EN
  localparam int LW = $clog2(MAX_LOCK + 1);
  logic [LW-1:0] lock_q, lock_d;

  always_comb begin
    prio_d = prio_q;
    lock_d = lock_q;
    if (m0_gnt) begin
      prio_d = 1'b1;
      lock_d = '0;
    end else if (m1_gnt && m1_lock) begin
      if (lock_q == LW'(MAX_LOCK - 1)) begin
        prio_d = 1'b0;
        lock_d = '0;
      end else begin
        prio_d = 1'b1;
        lock_d = lock_q + 1'b1;
      end
    end else if (m1_gnt) begin
      prio_d = 1'b0;
    end
    if (!m1_lock) lock_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= '0;
    else        lock_q <= lock_d;
  end
`else
  always_comb begin
    prio_d = prio_q;
    if (m0_gnt) prio_d = 1'b1;
    if (m1_gnt) prio_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q    <= 1'b0;
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m0_err    <= 1'b0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
      m1_err    <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      m0_rvalid <= m0_gnt;
      m1_rvalid <= m1_gnt;
      if (m0_gnt) begin
        m0_rdata <= sel_rd;
        m0_err   <= ~sel_inr;
      end
      if (m1_gnt) begin
        m1_rdata <= sel_rd;
        m1_err   <= ~sel_inr;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter.
// Includes a behavioural single-cycle dmem.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic        m1_lock;
`endif

  logic [31:0] mem [256];
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[9:2]];

  dmem_arbiter #(.MEM_DEPTH(256), .MAX_LOCK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .m1_lock(m1_lock),
`endif
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set1(input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
    m1_lock = 1'b0;
`endif
    set0(1, 0, 32'h0, 32'h0);
    set1(1, 0, 32'h4, 32'h0);
    #2;
    check("rst_gnt0", 32'(m0_gnt), 0);
    check("rst_gnt1", 32'(m1_gnt), 0);
    check("rst_rv0", 32'(m0_rvalid), 0);
    check("rst_rd0", m0_rdata, 0);
    check("rst_err1", 32'(m1_err), 0);
    check("rst_mrd", 32'(mem_read), 0);
    step();
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    step();
    rst_n = 1'b1;

    // write then read back on m0
    set0(1, 1, 32'h10, 32'hDEADBEEF);
    #1;
    check("t1_gnt_w", 32'(m0_gnt), 1);
    check("t1_mwr", 32'(mem_write), 1);
    check("t1_maddr", mem_addr, 32'h10);
    check("t1_mwd", mem_wdata, 32'hDEADBEEF);
    step();
    check("t1_rv_w", 32'(m0_rvalid), 1);
    check("t1_rd_w", m0_rdata, 0);
    set0(1, 1, 32'h0, 32'h11111111);
    step();
    set0(0, 0, 0, 0);
    set1(1, 1, 32'h4, 32'h22222222);
    #1;
    check("t1_gnt1", 32'(m1_gnt), 1);
    check("t1_gnt0n", 32'(m0_gnt), 0);
    step();
    check("t1_rv1", 32'(m1_rvalid), 1);
    check("t1_rv0n", 32'(m0_rvalid), 0);
    set1(0, 0, 0, 0);
    set0(1, 0, 32'h10, 0);
    #1;
    check("t1_gnt_r", 32'(m0_gnt), 1);
    check("t1_mrd", 32'(mem_read), 1);
    check("t1_mwr_n", 32'(mem_write), 0);
    step();
    check("t1_rv_r", 32'(m0_rvalid), 1);
    check("t1_rd_r", m0_rdata, 32'hDEADBEEF);

    // continuous conflict alternates
    set0(0, 0, 0, 0);
    do_reset();
    set0(1, 0, 32'h0, 0);
    set1(1, 0, 32'h4, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t2_g0_%0d", k), 32'(m0_gnt), 32'(k % 2 == 0));
      check($sformatf("t2_g1_%0d", k), 32'(m1_gnt), 32'(k % 2 == 1));
      step();
      check($sformatf("t2_v0_%0d", k), 32'(m0_rvalid), 32'(k % 2 == 0));
      check($sformatf("t2_v1_%0d", k), 32'(m1_rvalid), 32'(k % 2 == 1));
      if (k % 2 == 0) check($sformatf("t2_d0_%0d", k), m0_rdata, 32'h11111111);
      else            check($sformatf("t2_d1_%0d", k), m1_rdata, 32'h22222222);
    end

    // out-of-range accesses on m1
    set0(0, 0, 0, 0);
    set1(1, 1, 32'h400, 32'hBAD0BAD0);
    #1;
    check("t3_gnt", 32'(m1_gnt), 1);
    check("t3_mwr", 32'(mem_write), 0);
    check("t3_mrd", 32'(mem_read), 0);
    step();
    check("t3_rv", 32'(m1_rvalid), 1);
    check("t3_err", 32'(m1_err), 1);
    check("t3_rd", m1_rdata, 0);
    check("t3_mem0", mem[0], 32'h11111111);
    set1(1, 0, 32'h400, 0);
    #1;
    check("t3_mrd_oor", 32'(mem_read), 0);
    step();
    check("t3_err_r", 32'(m1_err), 1);
    check("t3_rd_r", m1_rdata, 0);
    set1(1, 0, 32'h4, 0);
    step();
    check("t3_err_clr", 32'(m1_err), 0);
    check("t3_rd_ok", m1_rdata, 32'h22222222);

    // async reset during an m0 read grant
    set1(0, 0, 0, 0);
    set0(1, 0, 32'h10, 0);
    step();
    check("t4_pre_rd", m0_rdata, 32'hDEADBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_rv", 32'(m0_rvalid), 0);
    check("t4_rd", m0_rdata, 0);
    check("t4_err", 32'(m0_err), 0);
    check("t4_gnt", 32'(m0_gnt), 0);
    step();
    set0(0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    check("t4_rv_post", 32'(m0_rvalid), 0);
    check("t4_rd_post", m0_rdata, 0);
    set0(1, 0, 32'h10, 0);
    set1(1, 0, 32'h4, 0);
    #1;
    check("t4_prio0", 32'(m0_gnt), 1);
    check("t4_prio1", 32'(m1_gnt), 0);
    step();

    // m1 alone three times, then conflict goes to m0
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    do_reset();
    set1(1, 0, 32'h4, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t5_g1_%0d", k), 32'(m1_gnt), 1);
      step();
    end
    set0(1, 0, 32'h10, 0);
    #1;
    check("t5_g0", 32'(m0_gnt), 1);
    check("t5_g1n", 32'(m1_gnt), 0);
    step();
    check("t5_rd0", m0_rdata, 32'hDEADBEEF);
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    #1;
    check("t5_idle_a", mem_addr, 0);
    check("t5_idle_r", 32'(mem_read), 0);
    step();
    check("t5_idle_v", 32'(m0_rvalid), 0);
    check("t5_hold_d", m0_rdata, 32'hDEADBEEF);

`ifdef DMEM_ARB_LOCK_EN
    begin
      logic [6:0] exp1;
      exp1 = 7'b1011110;
      do_reset();
      m1_lock = 1'b1;
      set0(1, 0, 32'h0, 0);
      set1(1, 0, 32'h4, 0);
      for (int k = 0; k < 7; k++) begin
        #1;
        check($sformatf("t6_g1_%0d", k), 32'(m1_gnt), 32'(exp1[k]));
        step();
      end
      m1_lock = 1'b0;
      set0(0, 0, 0, 0);
      set1(0, 0, 0, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
